alink_rx_fifo: RTL and testbench
================================

# alink_rx_fifo

Packet-aware receive FIFO directly downstream of the alink RX PHY. It captures each 5-word nonce report (RXID, TaskID_H, TaskID_L, TIME, NONCE) delivered on rx_start/rx_vld/rx_dat/rx_last. A report becomes visible only once all its words have arrived, so partial or oversized reports are never exposed. The register/CPU side drains it one word at a time through a first-word-fall-through read port.

## Interface
- DEPTH_LOG2, 6, log2 of storage depth in 32-bit words (64 words default)
- PKT_LEN, 5, words per report; must equal the PHY report length
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- reg_flush  in  1  synchronous clear of FIFO contents and state
- rx_start  in  1  one-cycle pulse, report begins; first rx_vld follows next cycle
- rx_vld  in  1  rx_dat valid this cycle
- rx_dat  in  32  report word
- rx_last  in  1  qualifies final word, coincident with rx_vld
- rd_en  in  1  pop head word
- rd_dat  out  32  head word, valid whenever rxfifo_empty=0
- rxfifo_empty  out  1  no committed words
- rxfifo_cnt  out  DEPTH_LOG2+1  committed unread words
- drop_cnt  out  16  reports dropped for lack of space, saturating at 16'hffff
- len_err  out  1  sticky, a report ended with a word count other than PKT_LEN

## Operation
- Storage: 2^DEPTH_LOG2 x 32 array. Pointers are DEPTH_LOG2+1 bits with wrap bit: rd_ptr, committed wr_ptr_c, speculative wr_ptr_s, plus a word counter wcnt of DEPTH_LOG2+1 bits. Address is pointer[DEPTH_LOG2-1:0].
- rxfifo_cnt = wr_ptr_c - rd_ptr (modulo 2^(DEPTH_LOG2+1)). free = 2^DEPTH_LOG2 - rxfifo_cnt.
- FSM states IDLE, RECV, DROP.
- IDLE: on rx_start, wr_ptr_s <= wr_ptr_c and wcnt <= 0. If free >= PKT_LEN, go to RECV. Otherwise go to DROP and increment drop_cnt (saturating). rx_vld in IDLE is ignored.
- RECV: each rx_vld writes rx_dat to mem[wr_ptr_s], then wr_ptr_s++ and wcnt++.
  - rx_vld with rx_last and wcnt+1 == PKT_LEN: commit wr_ptr_c <= wr_ptr_s+1, go to IDLE.
  - rx_vld with rx_last and wcnt+1 != PKT_LEN: no commit, set len_err, go to IDLE.
  - rx_vld without rx_last and wcnt+1 == PKT_LEN: go to IDLE, set len_err, no commit. The over-long tail is ignored.
- DROP: ignore rx_vld. On rx_vld with rx_last, go to IDLE.
- rx_start while in RECV or DROP aborts the current report (no commit, len_err set) and re-evaluates space exactly as from IDLE.
- Read: rd_dat = mem[rd_ptr[DEPTH_LOG2-1:0]], combinational from the array. rd_en with rxfifo_empty=0 increments rd_ptr. rd_en while empty is ignored.
- Speculative writes only target free locations, because space is checked at rx_start and reads only grow free space.
- reg_flush: all pointers to 0, wcnt to 0, state to IDLE, drop_cnt to 0, len_err to 0. Array contents are not cleared. reg_flush has priority over every other event in that cycle.

## Timing
- Reset (rst_n low): pointers 0, state IDLE, rxfifo_empty=1, rxfifo_cnt=0, drop_cnt=0, len_err=0. rd_dat is undefined while empty.
- Commit latency: rx_last at cycle T; rxfifo_cnt rises by PKT_LEN and rxfifo_empty drops at T+1.
- Read: rd_en at cycle T; rd_dat shows the next word and rxfifo_cnt is decremented at T+1.
- Commit and rd_en in the same cycle are both honoured: rxfifo_cnt changes by PKT_LEN-1.
- Full boundary: with rxfifo_cnt = 2^DEPTH_LOG2 - PKT_LEN exactly, a report is accepted and the FIFO becomes exactly full. One fewer free word drops it.
- The drop decision uses free as of the rx_start cycle. A rd_en in that same cycle does not count toward free space.
- Pointer wrap is transparent; reports may straddle the array end.
- Back-to-back reports with rx_start in the cycle after rx_last are supported with no lost words.

## Test plan
- Single report 0x0,0x11,0x22,0x33,0xdeadbeef -> rxfifo_cnt=5 one cycle after rx_last. Five rd_en pops return the words in order; rxfifo_empty=1 after the fifth.
- Defaults, 13 back-to-back reports with no reads -> first 12 committed (rxfifo_cnt=60), 13th dropped, drop_cnt=1, len_err=0.
- Fill to 60, pop 1, send a report -> accepted (cnt=64). Pop all 64 -> order intact across the wrap.
- rx_last on the 3rd word -> rxfifo_cnt unchanged, len_err=1. The next well-formed report commits normally.
- reg_flush asserted mid-RECV with 10 committed words -> cnt=0, empty=1, drop_cnt=0. The remaining rx_vld words are ignored. The next report commits 5 words.
- rst_n asserted low asynchronously mid-report -> all outputs at reset values immediately. After release, a report commits correctly.

Source files
------------

// File: rtl/alink_rx_fifo.sv
// Packet-aware RX FIFO: stages each alink nonce report speculatively and exposes it to the
// FWFT read port only once the full PKT_LEN words have arrived; commit visible one cycle after rx_last.
module alink_rx_fifo #(
  parameter int DEPTH_LOG2 = 6,
  parameter int PKT_LEN    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_flush,
  input  logic                  rx_start,
  input  logic                  rx_vld,
  input  logic [31:0]           rx_dat,
  input  logic                  rx_last,
  input  logic                  rd_en,
  output logic [31:0]           rd_dat,
  output logic                  rxfifo_empty,
  output logic [DEPTH_LOG2:0]   rxfifo_cnt,
  output logic [15:0]           drop_cnt,
  output logic                  len_err
);

  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_c_q, wr_ptr_c_d;
  logic [PW-1:0]   wr_ptr_s_q, wr_ptr_s_d;
  logic [PW-1:0]   wcnt_q, wcnt_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic            len_err_q, len_err_d;
  logic [31:0]     mem_q [DEPTH];

  logic [PW-1:0]   cnt;
  logic [PW-1:0]   free;
  logic [PW-1:0]   wcnt_inc;
  logic            has_space;
  logic            full_len;
  logic            mem_we;

  assign cnt       = wr_ptr_c_q - rd_ptr_q;
  assign free      = PW'(DEPTH) - cnt;
  assign has_space = (free >= PW'(PKT_LEN));
  assign wcnt_inc  = wcnt_q + PW'(1);
  assign full_len  = (wcnt_inc == PW'(PKT_LEN));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; rx_start restarts from any state, flush overrides all
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = IDLE;
      RECV: if (rx_vld && (rx_last || full_len)) state_d = IDLE;
      DROP: if (rx_vld && rx_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rx_start) state_d = has_space ? RECV : DROP;
    if (reg_flush) state_d = IDLE;
  end

  // FSM outputs
  always_comb begin
    mem_we = (state_q == RECV) && rx_vld && !rx_start && !reg_flush;
  end

  // Pointer, counter and status next-state
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_c_d = wr_ptr_c_q;
    wr_ptr_s_d = wr_ptr_s_q;
    wcnt_d     = wcnt_q;
    drop_cnt_d = drop_cnt_q;
    len_err_d  = len_err_q;

    if (rd_en && !rxfifo_empty) rd_ptr_d = rd_ptr_q + 1'b1;

    if (rx_start) begin
      wr_ptr_s_d = wr_ptr_c_q;
      wcnt_d     = '0;
      if (state_q != IDLE) len_err_d = 1'b1;
      if (!has_space && drop_cnt_q != 16'hffff) drop_cnt_d = drop_cnt_q + 16'd1;
    end else if (mem_we) begin
      wr_ptr_s_d = wr_ptr_s_q + 1'b1;
      wcnt_d     = wcnt_inc;
      if (rx_last && full_len) begin
        wr_ptr_c_d = wr_ptr_s_q + 1'b1;
      end else if (rx_last || full_len) begin
        len_err_d = 1'b1;
      end
    end

    if (reg_flush) begin
      rd_ptr_d   = '0;
      wr_ptr_c_d = '0;
      wr_ptr_s_d = '0;
      wcnt_d     = '0;
      drop_cnt_d = '0;
      len_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_c_q <= '0;
      wr_ptr_s_q <= '0;
      wcnt_q     <= '0;
      drop_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_c_q <= wr_ptr_c_d;
      wr_ptr_s_q <= wr_ptr_s_d;
      wcnt_q     <= wcnt_d;
      drop_cnt_q <= drop_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  // Storage is not reset; speculative writes only ever land in free slots
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_s_q[DEPTH_LOG2-1:0]] <= rx_dat;
  end

  assign rd_dat       = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign rxfifo_empty = (cnt == '0);
  assign rxfifo_cnt   = cnt;
  assign drop_cnt     = drop_cnt_q;
  assign len_err      = len_err_q;

endmodule

// File: tb/tb_alink_rx_fifo.sv
// Bench for alink_rx_fifo: report-length vector table, scoreboard of committed words,
// and directed sequences for full boundary, wrap, flush and async reset.
module tb_alink_rx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_flush;
  logic        rx_start;
  logic        rx_vld;
  logic [31:0] rx_dat;
  logic        rx_last;
  logic        rd_en;
  logic [31:0] rd_dat;
  logic        rxfifo_empty;
  logic [6:0]  rxfifo_cnt;
  logic [15:0] drop_cnt;
  logic        len_err;

  alink_rx_fifo #(.DEPTH_LOG2(6), .PKT_LEN(5)) dut (
    .clk(clk), .rst_n(rst_n), .reg_flush(reg_flush),
    .rx_start(rx_start), .rx_vld(rx_vld), .rx_dat(rx_dat), .rx_last(rx_last),
    .rd_en(rd_en), .rd_dat(rd_dat), .rxfifo_empty(rxfifo_empty),
    .rxfifo_cnt(rxfifo_cnt), .drop_cnt(drop_cnt), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] sb[$];
  int          exp_cnt  = 0;
  int          exp_drop = 0;
  bit          exp_err  = 0;
  logic [31:0] seq      = 32'h1000_0000;
  logic [31:0] fixed_w [5];
  bit          use_fixed = 0;

  typedef struct {
    int n;
    bit last;
    int cnt;
    bit err;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_status(input string name);
    chk({name, "_cnt"},   32'(rxfifo_cnt),   32'(exp_cnt));
    chk({name, "_empty"}, 32'(rxfifo_empty), 32'(exp_cnt == 0));
    chk({name, "_drop"},  32'(drop_cnt),     32'(exp_drop));
    chk({name, "_lerr"},  32'(len_err),      32'(exp_err));
  endtask

  function automatic logic [31:0] next_word();
    seq = seq + 32'h0101_0103;
    return seq;
  endfunction

  task automatic model_clear();
    sb.delete();
    exp_cnt  = 0;
    exp_drop = 0;
    exp_err  = 0;
  endtask

  task automatic do_flush();
    reg_flush = 1'b1;
    @(negedge clk);
    reg_flush = 1'b0;
    model_clear();
  endtask

  // Sends one report of n words starting with rx_start; optionally pops on the start or last cycle
  task automatic send_report(input int n, input bit last, input bit pop_on_start, input bit pop_on_last);
    bit          acc;
    bit          term;
    logic [31:0] w[$];
    logic [31:0] val;
    acc = (64 - exp_cnt) >= 5;
    rx_start = 1'b1;
    if (pop_on_start && sb.size() > 0) begin
      chk("rd_dat_start_pop", rd_dat, sb[0]);
      void'(sb.pop_front());
      rd_en = 1'b1;
      exp_cnt--;
    end
    @(negedge clk);
    rx_start = 1'b0;
    rd_en    = 1'b0;
    for (int i = 0; i < n; i++) begin
      val = (use_fixed && i < 5) ? fixed_w[i] : next_word();
      rx_vld  = 1'b1;
      rx_dat  = val;
      rx_last = last && (i == n - 1);
      w.push_back(val);
      if (pop_on_last && i == n - 1 && sb.size() > 0) begin
        chk("rd_dat_last_pop", rd_dat, sb[0]);
        void'(sb.pop_front());
        rd_en = 1'b1;
        exp_cnt--;
      end
      @(negedge clk);
      rd_en = 1'b0;
    end
    rx_vld  = 1'b0;
    rx_last = 1'b0;
    term = last || (n >= 5);
    if (acc) begin
      if (n == 5 && last) begin
        foreach (w[k]) sb.push_back(w[k]);
        exp_cnt += 5;
      end else if (term) begin
        exp_err = 1;
      end
    end else begin
      exp_drop++;
    end
  endtask

  task automatic pop_one();
    logic [31:0] e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("pop_empty", 32'(rxfifo_empty), 32'd0);
      chk("rd_dat", rd_dat, e);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      exp_cnt--;
      chk("pop_cnt", 32'(rxfifo_cnt), 32'(exp_cnt));
    end
  endtask

  task automatic pop_all();
    while (sb.size() > 0) pop_one();
    chk("drained_empty", 32'(rxfifo_empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; reg_flush = 1'b0; rx_start = 1'b0; rx_vld = 1'b0;
    rx_dat = '0; rx_last = 1'b0; rd_en = 1'b0;
    vecs[0] = '{n: 5, last: 1'b1, cnt: 5, err: 1'b0};
    vecs[1] = '{n: 3, last: 1'b1, cnt: 0, err: 1'b1};
    vecs[2] = '{n: 6, last: 1'b1, cnt: 0, err: 1'b1};
    vecs[3] = '{n: 1, last: 1'b1, cnt: 0, err: 1'b1};
    vecs[4] = '{n: 5, last: 1'b0, cnt: 0, err: 1'b1};
    vecs[5] = '{n: 4, last: 1'b0, cnt: 0, err: 1'b0};
    fixed_w[0] = 32'h0; fixed_w[1] = 32'h11; fixed_w[2] = 32'h22;
    fixed_w[3] = 32'h33; fixed_w[4] = 32'hdeadbeef;

    repeat (2) @(negedge clk);
    chk_status("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single report with fixed words; count must still be 0 while rx_last is on the bus
    rx_start = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx_vld = 1'b1; rx_dat = fixed_w[i]; rx_last = (i == 4);
      if (i == 4) chk("cnt_before_commit", 32'(rxfifo_cnt), 32'd0);
      @(negedge clk);
    end
    rx_vld = 1'b0; rx_last = 1'b0;
    for (int i = 0; i < 5; i++) sb.push_back(fixed_w[i]);
    exp_cnt = 5;
    chk_status("single");
    pop_all();

    // rd_en while empty must not move the read pointer
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk_status("rd_empty");
    send_report(5, 1, 0, 0);
    chk_status("after_rd_empty");
    pop_all();

    // Length vectors
    for (int v = 0; v < 6; v++) begin
      do_flush();
      send_report(vecs[v].n, vecs[v].last, 0, 0);
      chk($sformatf("vec%0d_cnt", v), 32'(rxfifo_cnt), 32'(vecs[v].cnt));
      chk($sformatf("vec%0d_lerr", v), 32'(len_err), 32'(vecs[v].err));
      chk_status($sformatf("vec%0d", v));
      pop_all();
    end

    // 13 back-to-back reports: 12 fit, 13th dropped at 4 free words
    do_flush();
    for (int r = 0; r < 13; r++) send_report(5, 1, 0, 0);
    chk("b2b_cnt60", 32'(rxfifo_cnt), 32'd60);
    chk_status("b2b");
    pop_one();
    send_report(5, 1, 0, 0);
    chk("full_cnt64", 32'(rxfifo_cnt), 32'd64);
    chk_status("full");
    send_report(5, 1, 0, 0);
    chk("full_drop2", 32'(drop_cnt), 32'd2);
    chk_status("full_drop");
    pop_all();

    // Commit and pop in the same cycle
    do_flush();
    send_report(5, 1, 0, 0);
    send_report(5, 1, 0, 1);
    chk("commit_pop_cnt9", 32'(rxfifo_cnt), 32'd9);
    chk_status("commit_pop");
    pop_all();

    // Pop coinciding with rx_start does not rescue a report at 4 free words
    do_flush();
    for (int r = 0; r < 12; r++) send_report(5, 1, 0, 0);
    send_report(5, 1, 1, 0);
    chk("start_pop_drop", 32'(drop_cnt), 32'd1);
    chk_status("start_pop");
    pop_all();

    // rx_start mid-report aborts it
    do_flush();
    rx_start = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rx_vld = 1'b1; rx_dat = next_word();
      @(negedge clk);
    end
    rx_vld = 1'b0;
    exp_err = 1;
    send_report(5, 1, 0, 0);
    chk_status("abort");
    pop_all();

    // Flush in the middle of a report with 10 committed words
    do_flush();
    send_report(5, 1, 0, 0);
    send_report(5, 1, 0, 0);
    rx_start = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx_vld = 1'b1; rx_dat = next_word(); rx_last = (i == 4);
      reg_flush = (i == 2);
      @(negedge clk);
      reg_flush = 1'b0;
      if (i == 2) model_clear();
    end
    rx_vld = 1'b0; rx_last = 1'b0;
    chk_status("flush_mid");
    send_report(5, 1, 0, 0);
    chk_status("after_flush");
    pop_all();

    // Asynchronous reset mid-report, away from the clock edge
    do_flush();
    send_report(5, 1, 0, 0);
    send_report(3, 1, 0, 0);
    chk_status("pre_reset");
    rx_start = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
    rx_vld = 1'b1; rx_dat = next_word();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk_status("async_reset");
    @(negedge clk);
    rx_vld = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    send_report(5, 1, 0, 0);
    chk_status("after_reset");
    pop_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
